cory_skid: RTL and testbench



---
 rtl/cory_skid_pkg.sv | 21 ++
 rtl/cory_skid.sv | 95 +++++++++
 tb/tb_cory_skid.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cory_skid_pkg.sv
// cory_skid shared definitions: state encoding for the two-entry register slice.
`ifndef CORY_SKID_PKG_SV
`define CORY_SKID_PKG_SV

package cory_skid_pkg;

    localparam int unsigned CORY_SKID_STATE_W = 2;

    localparam logic [CORY_SKID_STATE_W-1:0] CORY_SKID_EMPTY = 2'd0;
    localparam logic [CORY_SKID_STATE_W-1:0] CORY_SKID_HALF  = 2'd1;
    localparam logic [CORY_SKID_STATE_W-1:0] CORY_SKID_FULL  = 2'd2;

    typedef enum logic [CORY_SKID_STATE_W-1:0] {
        ST_EMPTY = CORY_SKID_EMPTY,
        ST_HALF  = CORY_SKID_HALF,
        ST_FULL  = CORY_SKID_FULL
    } cory_skid_state_t;

endpackage

`endif

// File: rtl/cory_skid.sv
// cory_skid: two-entry valid/ready register slice. Both o_z_* and o_a_ready
// come straight from flops, so neither the forward nor the backward
// handshake path is combinational through this block.
// Optional macro CORY_SKID_STAT_EN adds o_xfer_cnt and o_stall.
module cory_skid
    import cory_skid_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a_valid,
    input  logic [N-1:0] i_a_data,
    output logic         o_a_ready,
    output logic         o_z_valid,
    output logic [N-1:0] o_z_data,
`ifdef CORY_SKID_STAT_EN
    output logic [31:0]  o_xfer_cnt,
    output logic [0:0]   o_stall,
`endif
    input  logic         i_z_ready
);

    cory_skid_state_t state;
    logic [N-1:0]     skid_q;
    logic             a_xfer_c;
    logic             z_xfer_c;

    // Handshake qualifiers, both built only from flops and the partner's inputs
    assign a_xfer_c = i_a_valid & o_a_ready;
    assign z_xfer_c = o_z_valid & i_z_ready;

    // Slice FSM: occupancy, main/skid registers and the flopped handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            o_z_valid <= 1'b0;
            o_a_ready <= 1'b1;
            o_z_data  <= '0;
            skid_q    <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (a_xfer_c) begin
                        state     <= ST_HALF;
                        o_z_data  <= i_a_data;
                        o_z_valid <= 1'b1;
                    end
                end
                ST_HALF: begin
                    if (a_xfer_c && !z_xfer_c) begin
                        // Downstream stalled: park the new word, stop upstream
                        state     <= ST_FULL;
                        skid_q    <= i_a_data;
                        o_a_ready <= 1'b0;
                    end else if (a_xfer_c && z_xfer_c) begin
                        o_z_data  <= i_a_data;
                    end else if (z_xfer_c) begin
                        state     <= ST_EMPTY;
                        o_z_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // o_a_ready is low here, so only the drain move is possible
                    if (z_xfer_c) begin
                        state     <= ST_HALF;
                        o_z_data  <= skid_q;
                        o_a_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    o_z_valid <= 1'b0;
                    o_a_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CORY_SKID_STAT_EN
    // Downstream transfer counter (free-running, wraps) and registered stall flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_xfer_cnt <= '0;
            o_stall    <= '0;
        end else begin
            if (z_xfer_c) begin
                o_xfer_cnt <= o_xfer_cnt + 32'd1;
            end
            o_stall <= 1'(o_z_valid & ~i_z_ready);
        end
    end
`endif

endmodule

// File: tb/tb_cory_skid.sv
// Self-checking bench for cory_skid: queue scoreboard plus occupancy-derived
// expectations for o_z_valid / o_a_ready.
module tb_cory_skid;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_a_valid;
    logic [N-1:0] i_a_data;
    logic         o_a_ready;
    logic         o_z_valid;
    logic [N-1:0] o_z_data;
    logic         i_z_ready;
`ifdef CORY_SKID_STAT_EN
    logic [31:0]  o_xfer_cnt;
    logic [0:0]   o_stall;
`endif

    cory_skid #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_a_valid (i_a_valid),
        .i_a_data  (i_a_data),
        .o_a_ready (o_a_ready),
        .o_z_valid (o_z_valid),
        .o_z_data  (o_z_data),
`ifdef CORY_SKID_STAT_EN
        .o_xfer_cnt(o_xfer_cnt),
        .o_stall   (o_stall),
`endif
        .i_z_ready (i_z_ready)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] sb[$];
    logic         stall_prev;
    logic [N-1:0] held;
    int unsigned  cnt_exp;
    logic         stall_exp;
    int           stall_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check current outputs, account the transfers of the coming edge
    task automatic tick();
        logic in_x;
        logic out_x;
        chk("z_valid", 32'(o_z_valid), 32'(sb.size() > 0));
        chk("a_ready", 32'(o_a_ready), 32'(sb.size() < 2));
        if (sb.size() > 0) chk("z_data", 32'(o_z_data), 32'(sb[0]));
        if (stall_prev) begin
            chk("hold_valid", 32'(o_z_valid), 32'd1);
            chk("hold_data", 32'(o_z_data), 32'(held));
        end
        in_x  = i_a_valid & o_a_ready;
        out_x = o_z_valid & i_z_ready;
        stall_prev = o_z_valid & ~i_z_ready;
        held       = o_z_data;
        stall_exp  = stall_prev;
        if (out_x) begin
            if (sb.size() > 0) void'(sb.pop_front());
            cnt_exp++;
        end
        if (in_x) sb.push_back(i_a_data);
        @(negedge clk);
`ifdef CORY_SKID_STAT_EN
        chk("xfer_cnt", o_xfer_cnt, 32'(cnt_exp));
        chk("stall", 32'(o_stall), 32'(stall_exp));
        if (o_stall == 1'b1) stall_seen++;
`endif
    endtask

    // Offer one word upstream until accepted (bounded)
    task automatic push_word(input logic [N-1:0] d);
        logic acc;
        acc = 1'b0;
        i_a_valid = 1'b1;
        i_a_data  = d;
        for (int k = 0; k < 50; k++) begin
            acc = o_a_ready;
            tick();
            if (acc) break;
        end
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
        i_a_valid = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_z_valid", 32'(o_z_valid), 32'd0);
        chk("rst_a_ready", 32'(o_a_ready), 32'd1);
        sb.delete();
        stall_prev = 1'b0;
        stall_exp  = 1'b0;
        cnt_exp    = 0;
        stall_seen = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        i_a_valid  = 1'b0;
        i_a_data   = '0;
        i_z_ready  = 1'b0;
        stall_prev = 1'b0;
        stall_exp  = 1'b0;
        held       = '0;
        cnt_exp    = 0;
        stall_seen = 0;
        @(negedge clk);
        do_reset();
        chk("init_data", 32'(o_z_data), 32'd0);
        tick();

        // Reset while FULL, then first word after release
        i_z_ready = 1'b0;
        push_word(8'h33);
        push_word(8'h44);
        chk("full_ready", 32'(o_a_ready), 32'd0);
        do_reset();
        push_word(8'h11);
        chk("post_rst_data", 32'(o_z_data), 32'h11);
        chk("post_rst_valid", 32'(o_z_valid), 32'd1);
        i_z_ready = 1'b1;
        tick();
        tick();

        // Streaming at full rate
        i_z_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            i_a_valid = 1'b1;
            i_a_data  = N'(i);
            tick();
        end
        i_a_valid = 1'b0;
        chk("stream_last", 32'(o_z_data), 32'hFF);
        tick();
        tick();

        // Backpressure: A1, A2 accepted, A3 held upstream
        i_z_ready = 1'b0;
        i_a_valid = 1'b1;
        i_a_data  = 8'hA1;
        tick();
        i_a_data  = 8'hA2;
        tick();
        i_a_data  = 8'hA3;
        chk("bp_ready", 32'(o_a_ready), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("bp_data", 32'(o_z_data), 32'hA1);
        i_z_ready = 1'b1;
        push_word(8'hA3);
        for (int i = 0; i < 4; i++) tick();

        // Drain from FULL
        i_z_ready = 1'b0;
        push_word(8'h5A);
        push_word(8'hC3);
        chk("drain_full", 32'(o_a_ready), 32'd0);
        chk("drain_d0", 32'(o_z_data), 32'h5A);
        i_z_ready = 1'b1;
        tick();
        chk("drain_d1", 32'(o_z_data), 32'hC3);
        chk("drain_rdy", 32'(o_a_ready), 32'd1);
        tick();
        chk("drain_empty", 32'(o_z_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            i_a_valid = 1'($urandom_range(0, 1));
            i_a_data  = N'($urandom);
            i_z_ready = ($urandom_range(0, 99) < 30);
            tick();
        end
        i_a_valid = 1'b0;
        i_z_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("rand_drained", 32'(o_z_valid), 32'd0);

`ifdef CORY_SKID_STAT_EN
        // 300 transfers with exactly 7 stall cycles
        do_reset();
        chk("stat_rst_cnt", o_xfer_cnt, 32'd0);
        chk("stat_rst_stall", 32'(o_stall), 32'd0);
        for (int k = 0; k < 400; k++) begin
            if (cnt_exp >= 300) break;
            i_a_valid = 1'b1;
            i_a_data  = N'(k);
            i_z_ready = !(k == 10 || k == 50 || k == 51 || k == 100 ||
                          k == 150 || k == 200 || k == 250);
            tick();
        end
        i_a_valid = 1'b0;
        chk("stat_cnt", o_xfer_cnt, 32'd300);
        chk("stat_stalls", 32'(stall_seen), 32'd7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
